// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader: pops bytes from a first-word-fall-through FIFO and serializes them LSB-first on a 16x-tick UART line.
module uart_tx_fifo_reader #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            tx_en,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_rd_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);
  localparam int SW = $clog2(SB_TICK);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          r_state, w_state_n;
  logic [SW-1:0]   r_s, w_s_n;
  logic [2:0]      r_n, w_n_n;
  logic [DBIT-1:0] r_b, w_b_n;
  logic            r_tx, w_tx_n;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= '0;
      r_b     <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_s     <= w_s_n;
      r_n     <= w_n_n;
      r_b     <= w_b_n;
      r_tx    <= w_tx_n;
    end
  end
  // s advances only on s_tick and restarts at every state change
  always_comb begin
    w_state_n    = r_state;
    w_s_n        = r_s;
    w_n_n        = r_n;
    w_b_n        = r_b;
    w_tx_n       = r_tx;
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_n = 1'b1;
        if (~fifo_empty & tx_en) begin
          fifo_rd   = 1'b1;
          w_b_n     = fifo_rd_data;
          w_s_n     = '0;
          w_state_n = START;
          w_tx_n    = 1'b0;
        end
      end
      START: if (s_tick) begin
        if (r_s == SW'(15)) begin
          w_state_n = DATA;
          w_s_n     = '0;
          w_n_n     = '0;
          w_tx_n    = r_b[0];
        end else w_s_n = r_s + SW'(1);
      end
      DATA: if (s_tick) begin
        if (r_s == SW'(15)) begin
          w_b_n = r_b >> 1;
          w_s_n = '0;
          if (r_n == 3'(DBIT - 1)) begin
            w_state_n = STOP;
            w_tx_n    = 1'b1;
          end else begin
            w_n_n  = r_n + 3'd1;
            w_tx_n = r_b[1];
          end
        end else w_s_n = r_s + SW'(1);
      end
      STOP: if (s_tick) begin
        if (r_s == SW'(SB_TICK - 1)) begin
          w_state_n    = IDLE;
          w_s_n        = '0;
          tx_done_tick = 1'b1;
        end else w_s_n = r_s + SW'(1);
      end
      default: w_state_n = IDLE;
    endcase
  end
  assign tx      = r_tx;
  assign tx_busy = r_state != IDLE;
endmodule
